ref_clk_training_ctrl: RTL and testbench



---
 rtl/ref_clk_training_pkg.sv | 33 +++
 rtl/ref_clk_training_ctrl_rx_window_checker.sv | 70 +++++++
 rtl/ref_clk_training_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_ref_clk_training_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_clk_training_pkg.sv
// ref_clk_training_pkg
// Shared types and constants for the CK0 reference-clock training controller:
// FSM state encoding, ERR_CODE values and default parameter values.
package ref_clk_training_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_CENTER,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NO_EDGE = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  localparam int DEF_TAP_W          = 8;
  localparam int DEF_MAX_TAPS       = 127;
  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_SAMPLE_CYCLES  = 32;
  localparam int DEF_CENTER_BACKOFF = 8;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ref_clk_training_ctrl_rx_window_checker.sv
// rx_window_checker
// Examines one sampling window of RX_DATA words for a single delay tap.
// The first window cycle captures the reference word; every later cycle
// flags the tap unstable if the word differs from it. With
// EYE_MONITOR_CHECK_EN defined, the eye-monitor early/late flags on any
// later cycle also mark the tap unstable.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   sample_en           high on every cycle of the window
//   rx_data             deserialized CK0 word
//   eye_early/eye_late  eye-monitor flags (EYE_MONITOR_CHECK_EN only)
//   done                last cycle of the window (combinational)
//   stable              last window held the reference word throughout
//   ref_word            word captured on the first window cycle
module rx_window_checker
  import ref_clk_training_pkg::*;
#(
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [7:0] rx_data,
`ifdef EYE_MONITOR_CHECK_EN
  input  logic       eye_early,
  input  logic       eye_late,
`endif
  output logic       done,
  output logic       stable,
  output logic [7:0] ref_word
);

  localparam int CNT_W = cnt_w(SAMPLE_CYCLES);

  logic             in_window;
  logic [CNT_W-1:0] remain;
  logic             unstable;
  logic             bad_word;

`ifdef EYE_MONITOR_CHECK_EN
  assign bad_word = (rx_data != ref_word) || eye_early || eye_late;
`else
  assign bad_word = (rx_data != ref_word);
`endif

  assign done   = sample_en && in_window && (remain == '0);
  assign stable = ~unstable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_window <= 1'b0;
      remain    <= '0;
      unstable  <= 1'b0;
      ref_word  <= '0;
    end else if (sample_en) begin
      if (!in_window) begin
        // remain counts the compare cycles still to come after this one
        ref_word  <= rx_data;
        unstable  <= 1'b0;
        in_window <= 1'b1;
        remain    <= CNT_W'(SAMPLE_CYCLES - 2);
      end else begin
        if (bad_word) unstable <= 1'b1;
        if (remain == '0) in_window <= 1'b0;
        else              remain    <= remain - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ref_clk_training_ctrl.sv
// ref_clk_training_ctrl
// Fabric-side training controller for the DDR4 CK0 reference-clock lane.
// Sweeps the IOD input delay line upward until the stable RX pattern changes
// (the clock edge), then backs off toward the eye centre and reports.
// Optional build macro: EYE_MONITOR_CHECK_EN (eye-monitor flags also count
// as instability; CLEAR_FLAGS pulses at the start of every sample window).
// Ports:
//   FAB_CLK, ARST_N             clock, async active-low reset
//   TRAIN_START                 single-cycle start request
//   RX_DATA                     deserialized CK0 word
//   EYE_MONITOR_EARLY/LATE      eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE     delay-line limit flag
//   DELAY_LINE_LOAD/MOVE        one-cycle delay-line pulses
//   DELAY_LINE_DIRECTION        1 = increment, 0 = decrement (with MOVE)
//   EYE_MONITOR_CLEAR_FLAGS     one-cycle eye-monitor clear pulse
//   BUSY, TRAIN_DONE, TRAIN_ERR status
//   ERR_CODE                    01 no edge, 10 out of range
//   EDGE_TAP, FINAL_TAP         edge tap and tap after back-off
//
// state    | meaning
// S_IDLE   | waiting for TRAIN_START after reset
// S_LOAD   | LOAD pulse out, delay line returning to static value
// S_SETTLE | waiting SETTLE_CYCLES after a load or move
// S_SAMPLE | examining RX words for the current tap
// S_EVAL   | deciding base / edge / give-up / next tap
// S_STEP   | increment MOVE pulse out
// S_CENTER | decrement MOVE pulse out, or back-off finished
// S_DONE   | success, results held
// S_ERR    | failure, ERR_CODE held
module ref_clk_training_ctrl
  import ref_clk_training_pkg::*;
#(
  parameter int TAP_W          = DEF_TAP_W,
  parameter int MAX_TAPS       = DEF_MAX_TAPS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES  = DEF_SAMPLE_CYCLES,
  parameter int CENTER_BACKOFF = DEF_CENTER_BACKOFF
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             TRAIN_START,
  input  logic [7:0]       RX_DATA,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [1:0]       ERR_CODE,
  output logic [TAP_W-1:0] EDGE_TAP,
  output logic [TAP_W-1:0] FINAL_TAP
);

  localparam int               SET_W     = cnt_w(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_INIT  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] MAX_TAP_V = TAP_W'(MAX_TAPS);
  localparam logic [TAP_W-1:0] BACKOFF_V = TAP_W'(CENTER_BACKOFF);

  state_t           state;
  logic [TAP_W-1:0] tap;
  logic [TAP_W-1:0] backoff_cnt;
  logic [SET_W-1:0] settle_tmr;
  logic [7:0]       base_word;
  logic             have_base;
  logic             backing_off;
  logic             after_move;

  logic             sample_en;
  logic             win_done;
  logic             win_stable;
  logic [7:0]       win_ref;
  logic [TAP_W-1:0] backoff_init;
  logic             edge_found;

  assign sample_en    = (state == S_SAMPLE);
  // Clamp so the back-off can never walk the tap below zero.
  assign backoff_init = (tap < BACKOFF_V) ? tap : BACKOFF_V;
  assign edge_found   = win_stable && have_base && (win_ref != base_word);

  rx_window_checker #(
    .SAMPLE_CYCLES (SAMPLE_CYCLES)
  ) u_rx_window_checker (
    .clk       (FAB_CLK),
    .rst_n     (ARST_N),
    .sample_en (sample_en),
    .rx_data   (RX_DATA),
`ifdef EYE_MONITOR_CHECK_EN
    .eye_early (EYE_MONITOR_EARLY),
    .eye_late  (EYE_MONITOR_LATE),
`endif
    .done      (win_done),
    .stable    (win_stable),
    .ref_word  (win_ref)
  );

`ifndef EYE_MONITOR_CHECK_EN
  logic unused_eye;
  assign unused_eye = EYE_MONITOR_EARLY ^ EYE_MONITOR_LATE;
`endif

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                   <= S_IDLE;
      tap                     <= '0;
      backoff_cnt             <= '0;
      settle_tmr              <= '0;
      base_word               <= '0;
      have_base               <= 1'b0;
      backing_off             <= 1'b0;
      after_move              <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      BUSY                    <= 1'b0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
      ERR_CODE                <= ERR_NONE;
      EDGE_TAP                <= '0;
      FINAL_TAP               <= '0;
    end else begin
      // pulse outputs are asserted on entry to the state that owns them
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (TRAIN_START) begin
            TRAIN_DONE      <= 1'b0;
            TRAIN_ERR       <= 1'b0;
            ERR_CODE        <= ERR_NONE;
            EDGE_TAP        <= '0;
            FINAL_TAP       <= '0;
            have_base       <= 1'b0;
            backing_off     <= 1'b0;
            after_move      <= 1'b0;
            tap             <= '0;
            BUSY            <= 1'b1;
            DELAY_LINE_LOAD <= 1'b1;
            state           <= S_LOAD;
          end
        end

        S_LOAD: begin
          tap        <= '0;
          after_move <= 1'b0;
          settle_tmr <= SET_INIT;
          state      <= S_SETTLE;
        end

        S_SETTLE: begin
          if (after_move && DELAY_LINE_OUT_OF_RANGE) begin
            ERR_CODE  <= ERR_RANGE;
            TRAIN_ERR <= 1'b1;
            BUSY      <= 1'b0;
            state     <= S_ERR;
          end else if (settle_tmr == '0) begin
            if (backing_off) begin
              if (backoff_cnt != '0) begin
                DELAY_LINE_MOVE      <= 1'b1;
                DELAY_LINE_DIRECTION <= 1'b0;
              end
              state <= S_CENTER;
            end else begin
`ifdef EYE_MONITOR_CHECK_EN
              EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
`endif
              state <= S_SAMPLE;
            end
          end else begin
            settle_tmr <= settle_tmr - 1'b1;
          end
        end

        S_SAMPLE: begin
          if (win_done) state <= S_EVAL;
        end

        S_EVAL: begin
          // Base capture does not end the evaluation: the tap limit still
          // decides between STEP and ERR, so STEP is never entered at MAX_TAPS.
          if (win_stable && !have_base) begin
            base_word <= win_ref;
            have_base <= 1'b1;
          end
          if (edge_found) begin
            EDGE_TAP    <= tap;
            backoff_cnt <= backoff_init;
            backing_off <= 1'b1;
            if (backoff_init != '0) begin
              DELAY_LINE_MOVE      <= 1'b1;
              DELAY_LINE_DIRECTION <= 1'b0;
            end
            state <= S_CENTER;
          end else if (tap == MAX_TAP_V) begin
            ERR_CODE  <= ERR_NO_EDGE;
            TRAIN_ERR <= 1'b1;
            BUSY      <= 1'b0;
            state     <= S_ERR;
          end else begin
            DELAY_LINE_MOVE      <= 1'b1;
            DELAY_LINE_DIRECTION <= 1'b1;
            state                <= S_STEP;
          end
        end

        S_STEP: begin
          tap        <= tap + 1'b1;
          after_move <= 1'b1;
          settle_tmr <= SET_INIT;
          state      <= S_SETTLE;
        end

        S_CENTER: begin
          if (backoff_cnt != '0) begin
            tap         <= tap - 1'b1;
            backoff_cnt <= backoff_cnt - 1'b1;
            after_move  <= 1'b1;
            settle_tmr  <= SET_INIT;
            state       <= S_SETTLE;
          end else begin
            FINAL_TAP  <= tap;
            TRAIN_DONE <= 1'b1;
            BUSY       <= 1'b0;
            state      <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_clk_training_ctrl.sv
module tb_ref_clk_training_ctrl;

  logic       FAB_CLK;
  logic       ARST_N;
  logic       TRAIN_START;
  logic [7:0] RX_DATA;
  logic       EYE_MONITOR_EARLY;
  logic       EYE_MONITOR_LATE;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       BUSY;
  logic       TRAIN_DONE;
  logic       TRAIN_ERR;
  logic [1:0] ERR_CODE;
  logic [7:0] EDGE_TAP;
  logic [7:0] FINAL_TAP;

  ref_clk_training_ctrl dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .TRAIN_START             (TRAIN_START),
    .RX_DATA                 (RX_DATA),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .BUSY                    (BUSY),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_ERR               (TRAIN_ERR),
    .ERR_CODE                (ERR_CODE),
    .EDGE_TAP                (EDGE_TAP),
    .FINAL_TAP               (FINAL_TAP)
  );

`ifdef EYE_MONITOR_CHECK_EN
  localparam bit EYE_EN = 1'b1;
`else
  localparam bit EYE_EN = 1'b0;
`endif

  typedef struct {
    string name;
    int    done;
    int    err;
    int    code;
    int    edge_tap;
    int    final_tap;
    int    model_tap;
    int    inc;
    int    dec;
    int    clr;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // IOD model / monitor state
  int iod_tap   = 0;
  int inc_moves = 0;
  int dec_moves = 0;
  int clr_cnt   = 0;
  bit overlap   = 0;
  bit went_neg  = 0;
  int mode      = 0;
  bit oor_arm   = 0;

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pattern(input int m, input int t);
    logic [7:0] w;
    case (m)
      0: w = (t < 20) ? 8'h55 : (t < 22) ? 8'($urandom) : 8'hAA;
      1: w = (t < 3) ? 8'h55 : 8'hAA;
      3: w = (t < 5) ? 8'h33 : (t < 10) ? 8'h55 : 8'hAA;
      default: w = 8'h55;
    endcase
    return w;
  endfunction

  // IOD model: follows LOAD/MOVE pulses and supplies RX_DATA for the tap.
  initial begin
    RX_DATA                 = 8'h55;
    EYE_MONITOR_EARLY       = 1'b0;
    EYE_MONITOR_LATE        = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    forever begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD) begin
        iod_tap   = 0;
        inc_moves = 0;
        dec_moves = 0;
        clr_cnt   = 0;
        overlap   = 0;
        went_neg  = 0;
      end
      if (DELAY_LINE_MOVE) begin
        if (DELAY_LINE_DIRECTION) begin
          iod_tap++;
          inc_moves++;
        end else begin
          iod_tap--;
          dec_moves++;
          if (iod_tap < 0) went_neg = 1;
        end
      end
      if (EYE_MONITOR_CLEAR_FLAGS) clr_cnt++;
      if (int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS) > 1)
        overlap = 1;
      DELAY_LINE_OUT_OF_RANGE = oor_arm && (inc_moves >= 5);
      EYE_MONITOR_EARLY       = (mode == 3) && (iod_tap <= 4);
      RX_DATA                 = pattern(mode, iod_tap);
    end
  end

  function automatic int all_outputs();
    return int'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                 EYE_MONITOR_CLEAR_FLAGS, BUSY, TRAIN_DONE, TRAIN_ERR,
                 ERR_CODE, EDGE_TAP, FINAL_TAP});
  endfunction

  task automatic push_exp(input string name, input int done, input int err, input int code,
                          input int edge_tap, input int final_tap, input int model_tap,
                          input int inc, input int dec, input int taps_sampled);
    exp_t e;
    e.name = name; e.done = done; e.err = err; e.code = code;
    e.edge_tap = edge_tap; e.final_tap = final_tap; e.model_tap = model_tap;
    e.inc = inc; e.dec = dec; e.clr = EYE_EN ? taps_sampled : 0;
    sb.push_back(e);
  endtask

  // Start a run, optionally re-pulse TRAIN_START at cycle poke, then score.
  task automatic run_case(input int m, input int poke);
    exp_t e;
    int   cyc;
    bit   finished;
    mode = m;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    chk_eq("load_latency", int'(DELAY_LINE_LOAD), 1);
    cyc      = 0;
    finished = 0;
    while (!finished && cyc < 20000) begin
      @(negedge FAB_CLK);
      cyc++;
      TRAIN_START = (poke != 0 && cyc == poke);
      finished = TRAIN_DONE || TRAIN_ERR;
    end
    TRAIN_START = 1'b0;
    e = sb.pop_front();
    chk_eq({e.name, "_finished"}, int'(finished), 1);
    repeat (3) @(negedge FAB_CLK);
    chk_eq({e.name, "_done"}, int'(TRAIN_DONE), e.done);
    chk_eq({e.name, "_err"}, int'(TRAIN_ERR), e.err);
    chk_eq({e.name, "_code"}, int'(ERR_CODE), e.code);
    chk_eq({e.name, "_busy"}, int'(BUSY), 0);
    chk_eq({e.name, "_edge_tap"}, int'(EDGE_TAP), e.edge_tap);
    chk_eq({e.name, "_final_tap"}, int'(FINAL_TAP), e.final_tap);
    chk_eq({e.name, "_model_tap"}, iod_tap, e.model_tap);
    chk_eq({e.name, "_inc_moves"}, inc_moves, e.inc);
    chk_eq({e.name, "_dec_moves"}, dec_moves, e.dec);
    chk_eq({e.name, "_clear_pulses"}, clr_cnt, e.clr);
    chk_eq({e.name, "_pulse_overlap"}, int'(overlap), 0);
    chk_eq({e.name, "_below_zero"}, int'(went_neg), 0);
  endtask

  initial begin
    int inc_snap;
    ARST_N      = 1'b0;
    TRAIN_START = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    chk_eq("reset_outputs", all_outputs(), 0);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    chk_eq("idle_busy", int'(BUSY), 0);

    // edge at 22, full back-off
    push_exp("edge22", 1, 0, 0, 22, 14, 14, 22, 8, 23);
    run_case(0, 0);

    // edge at 3, back-off clamped to 3
    push_exp("edge3", 1, 0, 0, 3, 0, 0, 3, 3, 4);
    run_case(1, 0);

    // no edge anywhere
    push_exp("no_edge", 0, 1, 1, 0, 0, 127, 127, 0, 128);
    run_case(2, 0);

    // out of range after the 5th MOVE
    oor_arm = 1;
    push_exp("oor", 0, 1, 2, 0, 0, 5, 5, 0, 5);
    run_case(2, 0);
    oor_arm = 0;

    // TRAIN_START mid-sweep is ignored
    push_exp("restart_ignored", 1, 0, 0, 22, 14, 14, 22, 8, 23);
    run_case(0, 500);

    // reset mid-sweep aborts with everything cleared and no further pulses
    mode = 0;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    repeat (300) @(negedge FAB_CLK);
    ARST_N = 1'b0;
    #1;
    chk_eq("abort_outputs", all_outputs(), 0);
    inc_snap = inc_moves;
    repeat (50) @(negedge FAB_CLK);
    chk_eq("abort_outputs_held", all_outputs(), 0);
    chk_eq("abort_no_moves", inc_moves, inc_snap);
    ARST_N = 1'b1;
    push_exp("after_abort", 1, 0, 0, 3, 0, 0, 3, 3, 4);
    run_case(1, 0);

`ifdef EYE_MONITOR_CHECK_EN
    // EARLY high at taps 0-4 makes those taps unstable; base comes from tap 5
    push_exp("eye_early", 1, 0, 0, 10, 2, 2, 10, 8, 11);
    run_case(3, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
